sd_resp_crc7_check: RTL and testbench
=====================================

Name: sd_resp_crc7_check

Overview:
Receive-side companion to the SD command CRC7 generator. It deserializes a 48-bit SD response (R1/R1b/R3/R6/R7 format) from the sampled CMD line and computes CRC7 (x^7+x^3+1) bit-serially over the first 40 bits. It then compares the result with the received CRC field and checks the start, transmission and end bits. It sits between the SD CMD-line sampler and the SD command controller FSM.

Parameters:
NCR_MAX, 64, maximum bit_valid strobes allowed in WAIT_START before timeout (Ncr plus margin)
CNT_W, 7, width of the Ncr timeout counter; must hold NCR_MAX

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge
sys_rst  in  1  asynchronous active-high reset
rx_arm  in  1  one-cycle pulse: start looking for a response start bit; ignored unless in IDLE
resp_no_crc  in  1  sampled with rx_arm; 1 = R3 (CRC field is all-ones and is not checked)
cmd_bit  in  1  sampled CMD-line level; qualified by bit_valid
bit_valid  in  1  one-cycle strobe at each SD-clock sample point
resp_data  out  40  received bits 47..8 (start, tx, index[5:0], payload[31:0]); MSB is the first bit received
resp_crc_rx  out  7  received CRC field
resp_crc_calc  out  7  locally computed CRC7
resp_done  out  1  one-cycle pulse; all result outputs are valid on this cycle
crc_ok  out  1  level, valid from resp_done until the next rx_arm
frame_err  out  1  level; transmission bit != 0 or end bit != 1
timeout  out  1  level; no start bit within NCR_MAX strobes

Behaviour:
- Reset (async): state=IDLE. All outputs are 0; the shift register, CRC register and counters are cleared.
- Bit acceptance: every cmd_bit sample is taken only on a cycle with bit_valid=1. bit_valid is at most one cycle in every two.
- States: IDLE, WAIT_START, RECV, CHECK.
- IDLE:
  - On rx_arm: clear crc_ok, frame_err, timeout, the CRC register, the bit counter and the Ncr counter; latch resp_no_crc; go to WAIT_START.
  - rx_arm in any other state is ignored.
- WAIT_START, on each bit_valid:
  - cmd_bit=0: the start bit. Shift it in, update the CRC, set bitcnt=1, go to RECV.
  - cmd_bit=1: increment the Ncr counter. When the counter reaches NCR_MAX, go to CHECK with timeout pending.
- RECV, on each bit_valid: shift cmd_bit into a 48-bit register MSB-first and increment bitcnt.
  - bitcnt 0..39: CRC update, with fb = crc[6]^cmd_bit; crc <= {crc[5:3], crc[2]^fb, crc[1:0], fb}.
  - bitcnt 40..46: the CRC field; no CRC update.
  - bitcnt 47: the end bit; after the shift, go to CHECK.
- CHECK (exactly one cycle, then IDLE):
  - Drive resp_data, resp_crc_rx and resp_crc_calc.
  - crc_ok = timeout ? 0 : (no_crc ? 1 : calc==rx).
  - frame_err = !timeout & (txbit | !endbit).
  - timeout is driven as flagged.
  - Pulse resp_done.
- Latency: resp_done is asserted exactly 1 sys_clk after the bit_valid cycle that carried the end bit, or 1 cycle after the timeout-causing strobe.
- Outputs hold their values until the next accepted rx_arm.
- A CRC mismatch does not suppress the data: resp_data is always presented.
- sys_rst asserted mid-frame aborts immediately to IDLE, with no resp_done.
- rx_arm and bit_valid in the same cycle while in IDLE: arm only; the bit is not sampled.
- Busy signalling (R1b DAT0) is out of scope.

Optional Feature:
SD_RESP_TIMEOUT_EN
- Defined: the Ncr counter and timeout behave as above.
- Undefined: no counter is built, timeout is tied to 0, and WAIT_START waits indefinitely, leaving only via sys_rst.

Test Plan:
- CMD55 R1 frame 0x37_00000120_83, sent after 5 idle-high strobes -> resp_done; resp_data=0x3700000120; resp_crc_rx=resp_crc_calc=0x41; crc_ok=1; frame_err=0.
- Same frame with payload bit 0 flipped (0x3700000121) -> resp_crc_calc!=0x41; crc_ok=0; frame_err=0; resp_data=0x3700000121.
- Frame 0x40_00000000 with CRC 0x4A, end bit 1 (tx bit=1) -> resp_crc_calc=0x4A; crc_ok=1; frame_err=1.
- R3 with resp_no_crc=1: 0x3F_80FF8000 with CRC field 0x7F -> crc_ok=1, whatever the calc value.
- SD_RESP_TIMEOUT_EN defined, NCR_MAX=64, cmd_bit held 1 -> resp_done on the cycle after the 64th strobe; timeout=1; crc_ok=0. Macro undefined -> no resp_done after 200 strobes.
- sys_rst pulsed after 20 bits of a frame, then re-arm and send a full good frame -> no resp_done for the aborted frame; the second frame gives crc_ok=1.

Source files
------------

// File: rtl/sd_resp_crc7_check.sv
`default_nettype none
// ============================================================================
// Module   : sd_resp_crc7_check
// Purpose  : Receive-side checker for 48-bit SD command responses (R1/R1b/
//            R3/R6/R7). Deserializes the sampled CMD line, computes CRC7
//            (x^7+x^3+1) over the first 40 bits, compares it with the
//            received CRC field and checks the transmission and end bits.
// Options  : `define SD_RESP_TIMEOUT_EN builds the Ncr start-bit timeout.
//            Without it, WAIT_START waits indefinitely and timeout stays 0.
// Ports    : sys_clk       - system clock, rising edge
//            sys_rst       - asynchronous active-high reset
//            rx_arm        - pulse: start hunting for a start bit (IDLE only)
//            resp_no_crc   - sampled with rx_arm; 1 = R3, CRC not checked
//            cmd_bit       - sampled CMD-line level, qualified by bit_valid
//            bit_valid     - one-cycle strobe per SD-clock sample point
//            resp_data     - received bits 47..8, MSB first received
//            resp_crc_rx   - received CRC field
//            resp_crc_calc - locally computed CRC7
//            resp_done     - one-cycle pulse, results valid on this cycle
//            crc_ok        - CRC status, held until next accepted rx_arm
//            frame_err     - transmission bit != 0 or end bit != 1
//            timeout       - no start bit within NCR_MAX strobes
// Revision : 1.0 - initial release
// ============================================================================
module sd_resp_crc7_check #(
  parameter int NCR_MAX = 64,
  parameter int CNT_W   = 7
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_arm,
  input  logic        resp_no_crc,
  input  logic        cmd_bit,
  input  logic        bit_valid,
  output logic [39:0] resp_data,
  output logic [6:0]  resp_crc_rx,
  output logic [6:0]  resp_crc_calc,
  output logic        resp_done,
  output logic        crc_ok,
  output logic        frame_err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RECV       = 2'd2,
    ST_CHECK      = 2'd3
  } state_t;

  localparam logic [5:0] C_LAST_CRC_BIT = 6'd39;
  localparam logic [5:0] C_END_BIT      = 6'd47;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [47:0] r_shift;
  logic [6:0]  r_crc;
  logic [5:0]  r_bitcnt;
  logic        r_no_crc;

  logic [39:0] r_resp_data;
  logic [6:0]  r_crc_rx;
  logic [6:0]  r_crc_calc;
  logic        r_crc_ok;
  logic        r_frame_err;
  logic        r_timeout;

  logic        w_to_pend;     // timeout flagged in WAIT_START, reported in CHECK
  logic        w_ncr_expire;  // this strobe is the one that exhausts the Ncr budget
  logic        w_crc_fb;
  logic [6:0]  w_crc_nxt;
  logic        w_crc_ok;
  logic        w_frame_err;

  assign w_crc_fb  = r_crc[6] ^ cmd_bit;
  assign w_crc_nxt = {r_crc[5:3], r_crc[2] ^ w_crc_fb, r_crc[1:0], w_crc_fb};

`ifdef SD_RESP_TIMEOUT_EN
  logic [CNT_W-1:0] r_ncr_cnt;
  logic [CNT_W-1:0] w_ncr_inc;
  logic             r_to_pend;

  assign w_ncr_inc    = r_ncr_cnt + 1'b1;
  assign w_ncr_expire = bit_valid && cmd_bit && (w_ncr_inc == CNT_W'(NCR_MAX));
  assign w_to_pend    = r_to_pend;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ncr_cnt <= '0;
      r_to_pend <= 1'b0;
    end else if (r_state == ST_IDLE && rx_arm) begin
      r_ncr_cnt <= '0;
      r_to_pend <= 1'b0;
    end else if (r_state == ST_WAIT_START && bit_valid && cmd_bit) begin
      r_ncr_cnt <= w_ncr_inc;
      if (w_ncr_expire) begin
        r_to_pend <= 1'b1;
      end
    end
  end
`else
  // Parameters are kept for interface compatibility with the timeout build.
  localparam int C_NCR_UNUSED = NCR_MAX + CNT_W;
  assign w_ncr_expire = 1'b0;
  assign w_to_pend    = 1'b0;
`endif

  // CHECK-cycle results; a timed-out frame never reports CRC good or frame error.
  assign w_crc_ok    = w_to_pend ? 1'b0 : (r_no_crc ? 1'b1 : (r_crc == r_shift[7:1]));
  assign w_frame_err = !w_to_pend && (r_shift[46] || !r_shift[0]);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_arm) begin
          w_state_nxt = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (bit_valid && !cmd_bit) begin
          w_state_nxt = ST_RECV;
        end else if (w_ncr_expire) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_RECV: begin
        if (bit_valid && r_bitcnt == C_END_BIT) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, CRC, bit counter and held results
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_shift     <= '0;
      r_crc       <= '0;
      r_bitcnt    <= '0;
      r_no_crc    <= 1'b0;
      r_resp_data <= '0;
      r_crc_rx    <= '0;
      r_crc_calc  <= '0;
      r_crc_ok    <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A bit_valid coinciding with rx_arm is deliberately not sampled.
          if (rx_arm) begin
            r_crc       <= '0;
            r_bitcnt    <= '0;
            r_no_crc    <= resp_no_crc;
            r_crc_ok    <= 1'b0;
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
          end
        end
        ST_WAIT_START: begin
          if (bit_valid && !cmd_bit) begin
            r_shift  <= {r_shift[46:0], cmd_bit};
            r_crc    <= w_crc_nxt;
            r_bitcnt <= 6'd1;
          end
        end
        ST_RECV: begin
          if (bit_valid) begin
            r_shift  <= {r_shift[46:0], cmd_bit};
            r_bitcnt <= r_bitcnt + 6'd1;
            if (r_bitcnt <= C_LAST_CRC_BIT) begin
              r_crc <= w_crc_nxt;
            end
          end
        end
        ST_CHECK: begin
          r_resp_data <= r_shift[47:8];
          r_crc_rx    <= r_shift[7:1];
          r_crc_calc  <= r_crc;
          r_crc_ok    <= w_crc_ok;
          r_frame_err <= w_frame_err;
          r_timeout   <= w_to_pend;
        end
        default: begin
        end
      endcase
    end
  end

  // Results are presented straight from the frame registers during CHECK so
  // they are valid together with resp_done, then held from the copies.
  assign resp_done     = (r_state == ST_CHECK);
  assign resp_data     = resp_done ? r_shift[47:8] : r_resp_data;
  assign resp_crc_rx   = resp_done ? r_shift[7:1]  : r_crc_rx;
  assign resp_crc_calc = resp_done ? r_crc         : r_crc_calc;
  assign crc_ok        = resp_done ? w_crc_ok      : r_crc_ok;
  assign frame_err     = resp_done ? w_frame_err   : r_frame_err;
  assign timeout       = resp_done ? w_to_pend     : r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sd_resp_crc7_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_resp_crc7_check
// Purpose  : Directed self-checking bench for sd_resp_crc7_check. Frames are
//            sent MSB first with bit_valid every other clock; expected CRC
//            values are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_resp_crc7_check;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx_arm = 1'b0;
  logic        resp_no_crc = 1'b0;
  logic        cmd_bit = 1'b1;
  logic        bit_valid = 1'b0;
  logic [39:0] resp_data;
  logic [6:0]  resp_crc_rx;
  logic [6:0]  resp_crc_calc;
  logic        resp_done;
  logic        crc_ok;
  logic        frame_err;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int base;

  sd_resp_crc7_check #(
    .NCR_MAX(64),
    .CNT_W  (7)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rx_arm       (rx_arm),
    .resp_no_crc  (resp_no_crc),
    .cmd_bit      (cmd_bit),
    .bit_valid    (bit_valid),
    .resp_data    (resp_data),
    .resp_crc_rx  (resp_crc_rx),
    .resp_crc_calc(resp_crc_calc),
    .resp_done    (resp_done),
    .crc_ok       (crc_ok),
    .frame_err    (frame_err),
    .timeout      (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (resp_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic b);
    @(negedge sys_clk);
    cmd_bit   = b;
    bit_valid = 1'b1;
    @(negedge sys_clk);
    bit_valid = 1'b0;
  endtask

  task automatic arm(input logic nc);
    @(negedge sys_clk);
    rx_arm      = 1'b1;
    resp_no_crc = nc;
    @(negedge sys_clk);
    rx_arm      = 1'b0;
    resp_no_crc = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Sends idle-high strobes then the 48-bit frame; returns on the cycle after
  // the end-bit strobe, where resp_done must be high.
  task automatic send_frame(input string tag, input logic [47:0] f, input int idle);
    int b0;
    b0 = done_cnt;
    for (int i = 0; i < idle; i++) strobe(1'b1);
    for (int i = 47; i >= 0; i--) strobe(f[i]);
    check({tag, "_done_latency"}, 64'(resp_done), 64'd1);
    check({tag, "_done_not_early"}, 64'(done_cnt - b0), 64'd0);
  endtask

  task automatic after_done(input string tag);
    @(negedge sys_clk);
    #1;
    check({tag, "_done_pulse_ends"}, 64'(resp_done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_done",     64'(resp_done),     64'd0);
    check("rst_crc_ok",   64'(crc_ok),        64'd0);
    check("rst_frame",    64'(frame_err),     64'd0);
    check("rst_timeout",  64'(timeout),       64'd0);
    check("rst_data",     64'(resp_data),     64'd0);
    check("rst_crc_calc", 64'(resp_crc_calc), 64'd0);
    sys_rst = 1'b0;

    // CMD55 R1 response, CRC 0x41
    arm(1'b0);
    send_frame("r1", {40'h3700000120, 8'h83}, 5);
    check("r1_data",   64'(resp_data),     64'h3700000120);
    check("r1_crc_rx", 64'(resp_crc_rx),   64'h41);
    check("r1_calc",   64'(resp_crc_calc), 64'h41);
    check("r1_crc_ok", 64'(crc_ok),        64'd1);
    check("r1_frame",  64'(frame_err),     64'd0);
    check("r1_to",     64'(timeout),       64'd0);
    after_done("r1");
    check("r1_hold_ok",   64'(crc_ok),    64'd1);
    check("r1_hold_data", 64'(resp_data), 64'h3700000120);

    // Last payload bit flipped: CRC differs by 0x09 -> 0x48
    arm(1'b0);
    send_frame("flip", {40'h3700000121, 8'h83}, 2);
    check("flip_data",   64'(resp_data),     64'h3700000121);
    check("flip_crc_rx", 64'(resp_crc_rx),   64'h41);
    check("flip_calc",   64'(resp_crc_calc), 64'h48);
    check("flip_crc_ok", 64'(crc_ok),        64'd0);
    check("flip_frame",  64'(frame_err),     64'd0);
    after_done("flip");

    // Transmission bit set: CRC good but frame error
    arm(1'b0);
    send_frame("txb", {40'h4000000000, 8'h95}, 1);
    check("txb_calc",   64'(resp_crc_calc), 64'h4A);
    check("txb_crc_ok", 64'(crc_ok),        64'd1);
    check("txb_frame",  64'(frame_err),     64'd1);
    after_done("txb");
    check("txb_hold_frame", 64'(frame_err), 64'd1);

    // R3: CRC field all ones, not checked
    arm(1'b1);
    send_frame("r3", {40'h3F80FF8000, 8'hFF}, 3);
    check("r3_data",   64'(resp_data),   64'h3F80FF8000);
    check("r3_crc_rx", 64'(resp_crc_rx), 64'h7F);
    check("r3_crc_ok", 64'(crc_ok),      64'd1);
    check("r3_frame",  64'(frame_err),   64'd0);
    after_done("r3");

    // Ncr timeout
    arm(1'b0);
    check("arm_clears_ok", 64'(crc_ok), 64'd0);
    base = done_cnt;
`ifdef SD_RESP_TIMEOUT_EN
    repeat (63) strobe(1'b1);
    check("to_not_early", 64'(resp_done), 64'd0);
    strobe(1'b1);
    check("to_done",   64'(resp_done), 64'd1);
    check("to_flag",   64'(timeout),   64'd1);
    check("to_crc_ok", 64'(crc_ok),    64'd0);
    check("to_frame",  64'(frame_err), 64'd0);
    after_done("to");
    check("to_hold",  64'(timeout),           64'd1);
    check("to_count", 64'(done_cnt - base),   64'd1);
`else
    repeat (200) strobe(1'b1);
    @(negedge sys_clk);
    #1;
    check("noto_no_done", 64'(done_cnt - base), 64'd0);
    check("noto_flag",    64'(timeout),         64'd0);
    pulse_reset();
`endif

    // Reset mid-frame aborts without resp_done; re-armed frame is good
    arm(1'b0);
    base = done_cnt;
    for (int i = 47; i >= 28; i--) begin
      logic [47:0] f;
      f = {40'h3700000120, 8'h83};
      strobe(f[i]);
    end
    pulse_reset();
    repeat (4) @(negedge sys_clk);
    #1;
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    check("abort_crc_ok",  64'(crc_ok),          64'd0);
    check("abort_data",    64'(resp_data),       64'd0);
    arm(1'b0);
    send_frame("rearm", {40'h3700000120, 8'h83}, 2);
    check("rearm_crc_ok", 64'(crc_ok),    64'd1);
    check("rearm_data",   64'(resp_data), 64'h3700000120);
    after_done("rearm");
    check("rearm_count", 64'(done_cnt - base), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
